// File: rtl/oled_send_arbiter.sv
// Round-robin arbiter that streams one requester's whole frame at a time
// onto the shared oledControl byte port (send_data/send_data_valid/send_done).
module oled_send_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [LEN_W-1:0]         byte_idx,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     busy,
    output logic [7:0]               send_data,
    output logic                     send_data_valid,
    input  logic                     send_done
);

    localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIN} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]   gidx, gidx_n;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W:0]     cand;
    logic [LEN_W-1:0]   sel_len, clamp_len, byte_idx_n;
    logic [NUM_REQ-1:0] grant_n, req_done_n;
    logic               busy_n, valid_n;
    logic [7:0]         send_data_n;

    // Scan farthest-first so the set bit nearest to rr_ptr is the last to overwrite pick.
    always_comb begin
        pick = rr_ptr;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (req[cand[PTR_W-1:0]]) begin
                pick = cand[PTR_W-1:0];
            end
        end
    end

    assign sel_len   = req_len[pick*LEN_W +: LEN_W];
    assign clamp_len = (sel_len > MAX_LEN_V) ? MAX_LEN_V : sel_len;

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        gidx_n      = gidx;
        grant_n     = grant;
        byte_idx_n  = byte_idx;
        req_done_n  = '0;
        busy_n      = busy;
        send_data_n = send_data;
        valid_n     = send_data_valid;
        case (state)
            IDLE: begin
                if (|req) begin
                    gidx_n     = pick;
                    grant_n    = NUM_REQ'(1) << pick;
                    busy_n     = 1'b1;
                    byte_idx_n = (clamp_len == '0) ? '0 : clamp_len - 1'b1;
                    state_n    = (clamp_len == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                // oledControl must have released done from the previous byte first.
                if (!send_done) begin
                    send_data_n = req_data[gidx*8 +: 8];
                    valid_n     = 1'b1;
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                if (send_done) begin
                    valid_n = 1'b0;
                    if (byte_idx == '0) begin
                        state_n = FIN;
                    end else begin
                        byte_idx_n = byte_idx - 1'b1;
                        state_n    = LOAD;
                    end
                end
            end
            FIN: begin
                req_done_n = grant;
                rr_ptr_n   = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
                grant_n    = '0;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            gidx            <= '0;
            grant           <= '0;
            byte_idx        <= '0;
            req_done        <= '0;
            busy            <= 1'b0;
            send_data       <= '0;
            send_data_valid <= 1'b0;
        end else begin
            state           <= state_n;
            rr_ptr          <= rr_ptr_n;
            gidx            <= gidx_n;
            grant           <= grant_n;
            byte_idx        <= byte_idx_n;
            req_done        <= req_done_n;
            busy            <= busy_n;
            send_data       <= send_data_n;
            send_data_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_oled_send_arbiter.sv
// Bench for oled_send_arbiter: frame-level model checked every cycle, an oledControl-like
// acknowledger, and directed scenarios with hand-computed expectations.
module tb_oled_send_arbiter;

    localparam int NREQ = 2;
    localparam int MAXL = 16;
    localparam int LW   = 5;
    localparam int ACK  = 4;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req;
    logic [9:0]  req_len;
    logic [15:0] req_data;
    logic [1:0]  grant;
    logic [4:0]  byte_idx;
    logic [1:0]  req_done;
    logic        busy;
    logic [7:0]  send_data;
    logic        send_data_valid;
    logic        send_done;

    int         tests = 0;
    int         fails = 0;
    int         hs_cnt = 0;
    logic [7:0] sent_q[$];
    logic       done_hold = 1'b0;
    logic [7:0] mem [2][32];

    oled_send_arbiter #(.NUM_REQ(NREQ), .MAX_LEN(MAXL), .LEN_W(LW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req             (req),
        .req_len         (req_len),
        .req_data        (req_data),
        .grant           (grant),
        .byte_idx        (byte_idx),
        .req_done        (req_done),
        .busy            (busy),
        .send_data       (send_data),
        .send_data_valid (send_data_valid),
        .send_done       (send_done)
    );

    // Each requester presents its byte for byte_idx combinationally.
    assign req_data = {mem[1][byte_idx], mem[0][byte_idx]};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // oledControl stand-in: done rises ACK cycles after valid, falls once valid drops.
    initial begin
        int ack_cnt;
        ack_cnt   = 0;
        send_done = 1'b0;
        forever begin
            @(negedge clock);
            if (done_hold) begin
                send_done = 1'b1;
            end else if (!send_data_valid) begin
                send_done = 1'b0;
                ack_cnt   = 0;
            end else if (!send_done) begin
                ack_cnt++;
                if (ack_cnt >= ACK) send_done = 1'b1;
            end
        end
    end

    int         m_ptr, m_g, m_len, m_sent;
    bit         m_busy, m_fin, m_due, m_inflight;
    logic [1:0] exp_done, exp_grant;
    logic [1:0] req_p;
    logic [9:0] len_p;
    logic       done_p, valid_prev;
    logic [7:0] data_prev;

    // Frame-level model: a frame is m_len bytes, highest index first, one per handshake.
    initial begin
        m_ptr = 0; m_g = 0; m_len = 0; m_sent = 0;
        m_busy = 0; m_fin = 0; m_due = 0; m_inflight = 0;
        exp_done = '0; valid_prev = 1'b0; data_prev = '0;
        forever begin
            @(posedge clock);
            req_p  = req;
            len_p  = req_len;
            done_p = send_done;
            #1;
            if (!reset_n) begin
                m_ptr = 0; m_busy = 0; m_fin = 0; m_due = 0; m_inflight = 0;
                exp_done = '0; valid_prev = 1'b0;
            end else begin
                if (valid_prev && done_p) begin
                    sent_q.push_back(data_prev);
                    hs_cnt++;
                end
                exp_done = '0;
                if (!m_busy) begin
                    if (req_p != 2'b00) begin
                        m_g = -1;
                        for (int k = 0; k < NREQ; k++)
                            if (m_g < 0 && req_p[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
                        m_len = int'(len_p[m_g*LW +: LW]);
                        if (m_len > MAXL) m_len = MAXL;
                        m_sent = 0;
                        m_busy = 1;
                        m_fin  = (m_len == 0);
                        m_due  = (m_len != 0);
                    end
                end else if (m_fin) begin
                    exp_done = 2'(1 << m_g);
                    m_busy   = 0;
                    m_fin    = 0;
                    m_ptr    = (m_g + 1) % NREQ;
                end else if (m_inflight) begin
                    if (done_p) begin
                        m_inflight = 0;
                        m_sent++;
                        if (m_sent == m_len) m_fin = 1;
                        else m_due = 1;
                    end
                end else if (m_due && !done_p) begin
                    m_inflight = 1;
                    m_due      = 0;
                end
                exp_grant = m_busy ? 2'(1 << m_g) : 2'b00;
                check_output("grant", 32'(grant), 32'(exp_grant));
                check_output("busy", 32'(busy), 32'(m_busy));
                check_output("req_done", 32'(req_done), 32'(exp_done));
                check_output("valid", 32'(send_data_valid), 32'(m_inflight));
                if (m_inflight)
                    check_output("send_data", 32'(send_data), 32'(mem[m_g][m_len-1-m_sent]));
                if (m_busy)
                    check_output("byte_idx", 32'(byte_idx), m_fin ? 32'd0 : 32'(m_len-1-m_sent));
                valid_prev = send_data_valid;
                data_prev  = send_data;
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] r, input logic [4:0] l0, input logic [4:0] l1);
        @(negedge clock);
        req     = r;
        req_len = {l1, l0};
    endtask

    task automatic wait_pulse(output logic [1:0] pulse, output int cycles);
        pulse  = '0;
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #2;
            cycles++;
            if (req_done != 2'b00) begin
                pulse = req_done;
                return;
            end
        end
        check_output("req_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_handshakes(input int target);
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #2;
            if (hs_cnt >= target) return;
        end
        check_output("handshake_timeout", 32'(hs_cnt), 32'(target));
    endtask

    logic [1:0] pulse;
    logic [1:0] ord [4];
    logic [1:0] exp_ord [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int         cycles, h0, s0;
    string      clk_str = "12:34:56";

    initial begin
        reset_n = 1'b0;
        req     = '0;
        req_len = '0;
        for (int i = 0; i < 8; i++) mem[0][7-i] = clk_str[i];
        for (int i = 8; i < 32; i++) mem[0][i] = 8'(8'h40 + i);
        for (int i = 0; i < 32; i++) mem[1][i] = 8'(8'hA0 + i);
        #12;
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(send_data_valid), 32'd0);
        check_output("rst_req_done", 32'(req_done), 32'd0);
        check_output("rst_byte_idx", 32'(byte_idx), 32'd0);
        check_output("rst_send_data", 32'(send_data), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] single frame \"12:34:56\" from requester 0");
        h0 = hs_cnt; s0 = sent_q.size();
        apply_stimulus(2'b01, 5'd8, 5'd0);
        @(posedge clock); #2;
        check_output("t1_valid_after_1", 32'(send_data_valid), 32'd0);
        @(posedge clock); #2;
        check_output("t1_valid_after_2", 32'(send_data_valid), 32'd1);
        check_output("t1_first_idx", 32'(byte_idx), 32'd7);
        wait_pulse(pulse, cycles);
        @(negedge clock); req = 2'b00;
        check_output("t1_done", 32'(pulse), 32'h1);
        check_output("t1_handshakes", 32'(hs_cnt - h0), 32'd8);
        if (sent_q.size() >= s0 + 8)
            for (int i = 0; i < 8; i++)
                check_output("t1_byte", 32'(sent_q[s0+i]), 32'(clk_str[i]));
        repeat (2) @(negedge clock);

        $display("[TB] zero-length frame on requester 1");
        h0 = hs_cnt;
        apply_stimulus(2'b10, 5'd0, 5'd0);
        wait_pulse(pulse, cycles);
        @(negedge clock); req = 2'b00;
        check_output("t3_zero_done", 32'(pulse), 32'h2);
        check_output("t3_zero_latency", 32'(cycles), 32'd2);
        check_output("t3_zero_no_bytes", 32'(hs_cnt - h0), 32'd0);
        repeat (2) @(negedge clock);

        $display("[TB] contention, both requesters held");
        h0 = hs_cnt;
        apply_stimulus(2'b11, 5'd8, 5'd5);
        for (int i = 0; i < 4; i++) begin
            wait_pulse(pulse, cycles);
            ord[i] = pulse;
            if (i == 2) begin
                @(negedge clock);
                @(negedge clock);
                req = 2'b00;
            end
        end
        for (int i = 0; i < 4; i++) check_output("t2_order", 32'(ord[i]), 32'(exp_ord[i]));
        check_output("t2_handshakes", 32'(hs_cnt - h0), 32'd26);
        repeat (3) @(negedge clock);

        $display("[TB] over-length frame clamps to 16 bytes");
        h0 = hs_cnt; s0 = sent_q.size();
        apply_stimulus(2'b01, 5'd31, 5'd0);
        wait_pulse(pulse, cycles);
        @(negedge clock); req = 2'b00;
        check_output("t3_long_done", 32'(pulse), 32'h1);
        check_output("t3_long_handshakes", 32'(hs_cnt - h0), 32'd16);
        if (sent_q.size() > s0) check_output("t3_long_first", 32'(sent_q[s0]), 32'h4F);
        repeat (2) @(negedge clock);

        $display("[TB] send_done stuck high while loading");
        h0 = hs_cnt;
        @(negedge clock); done_hold = 1'b1;
        apply_stimulus(2'b01, 5'd3, 5'd0);
        repeat (6) @(posedge clock);
        #2;
        check_output("t4_stuck_valid", 32'(send_data_valid), 32'd0);
        check_output("t4_stuck_busy", 32'(busy), 32'd1);
        @(negedge clock); done_hold = 1'b0;
        wait_pulse(pulse, cycles);
        @(negedge clock); req = 2'b00;
        check_output("t4_done", 32'(pulse), 32'h1);
        check_output("t4_handshakes", 32'(hs_cnt - h0), 32'd3);
        repeat (2) @(negedge clock);

        $display("[TB] request dropped mid-frame");
        h0 = hs_cnt;
        apply_stimulus(2'b01, 5'd8, 5'd0);
        wait_handshakes(h0 + 3);
        @(negedge clock); req = 2'b00;
        wait_pulse(pulse, cycles);
        check_output("t5_done", 32'(pulse), 32'h1);
        check_output("t5_handshakes", 32'(hs_cnt - h0), 32'd8);
        repeat (2) @(negedge clock);

        $display("[TB] asynchronous reset mid-frame");
        apply_stimulus(2'b01, 5'd8, 5'd0);
        for (int i = 0; i < 50 && send_data_valid !== 1'b1; i++) begin
            @(posedge clock); #2;
        end
        check_output("t6_valid_before", 32'(send_data_valid), 32'd1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        req     = 2'b00;
        #1;
        check_output("t6_rst_valid", 32'(send_data_valid), 32'd0);
        check_output("t6_rst_grant", 32'(grant), 32'd0);
        check_output("t6_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        apply_stimulus(2'b11, 5'd2, 5'd2);
        @(posedge clock); #2;
        check_output("t6_restart_grant", 32'(grant), 32'h1);
        @(negedge clock); req = 2'b00;
        wait_pulse(pulse, cycles);
        check_output("t6_done", 32'(pulse), 32'h1);
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
